ysyx_24110015_lsu: RTL and testbench
====================================

# ysyx_24110015_lsu

Parametrised, multi-cycle load/store stage that replaces the single-cycle, zero-latency memory access of the execute stage. It accepts one decoded operation at a time over a valid/ready handshake and performs at most one bus access. Each bus access uses separate request and response handshakes. Loads are byte-lane aligned and extended; stores get lane-shifted write data and strobes. Results and faults are returned over a second valid/ready handshake to writeback.

## Interface
Parameters:
- XLEN, 32, data/register width; legal values 32 or 64
- ADDR_W, 32, address width
- STRB_W, XLEN/8, derived, not overridable

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  LSU can accept (high only in IDLE)
- in_addr  in  ADDR_W  effective address / ALU result
- in_wdata  in  XLEN  store data (rs2), unshifted
- in_mem_read  in  1  load
- in_mem_write  in  1  store (takes priority if both set)
- in_mem_op  in  3  000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu, 111 illegal
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_req_wen  out  1  1 = write
- mem_req_addr  out  ADDR_W  address aligned down to STRB_W bytes
- mem_req_wdata  out  XLEN  lane-shifted store data
- mem_req_wstrb  out  STRB_W  byte strobes (all 0 for reads)
- mem_resp_valid  in  1  response present
- mem_resp_ready  out  1  high only in WAIT
- mem_resp_rdata  in  XLEN  full aligned word
- mem_resp_err  in  1  bus error
- out_valid  out  1  result ready
- out_ready  in  1  writeback consumes
- out_data  out  XLEN  load value, or in_addr for non-memory ops
- out_fault  out  1  misaligned, illegal op, or bus error

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: in_ready=1. The operation is accepted on in_valid&in_ready and all inputs are registered.
  - Non-memory op → DONE with out_data=in_addr, out_fault=0.
  - Illegal op → DONE with out_fault=1, out_data=0, no bus traffic.
    - d/wu are illegal when XLEN=32.
    - 111 is always illegal.
  - Misaligned op → DONE with out_fault=1, out_data=0, no bus traffic.
    - h requires addr[0]=0; w requires addr[1:0]=0; d requires addr[2:0]=0.
  - Otherwise → REQ.
- REQ: mem_req_valid=1 with all request fields stable until mem_req_ready. On the handshake → WAIT.
- WAIT: mem_resp_ready=1. On mem_resp_valid → DONE.
  - Load: out_data = (rdata >> 8*off) truncated to the access size, then sign- or zero-extended per in_mem_op. off = addr mod STRB_W.
  - Store: out_data=0.
  - mem_resp_err=1 gives out_fault=1 and out_data=0.
- DONE: out_valid=1 with out_data/out_fault stable until out_ready. On out_ready → IDLE. No new op is accepted in the same cycle.
- Store lane rule: wdata = in_wdata << 8*off. wstrb = ((1<<size)-1) << off, where size is 1/2/4/8 bytes.
- mem_resp_valid outside WAIT is ignored and not counted.
- Exactly one outstanding bus transaction at any time.

## Timing
- Reset (rst=1 at a rising edge) → state IDLE next cycle.
  - in_ready=1.
  - mem_req_valid=0, mem_resp_ready=0, out_valid=0.
  - out_data=0, out_fault=0, mem_req_*=0.
- Reset mid-transaction abandons the operation and drops mem_req_valid on the following cycle. A response arriving afterwards is ignored.
- Latency from accept edge (cycle 0):
  - Non-memory, fault, or illegal op: out_valid at cycle 1.
  - Memory op: mem_req_valid at cycle 1. With zero-wait ready and response at cycle 2, out_valid is at cycle 3.
- Back-to-back throughput:
  - Non-memory ops: one op per 2 cycles.
  - Memory ops: one op per 4 cycles minimum.
- Stalls: mem_req_ready low, mem_resp_valid late, or out_ready low each extend their state indefinitely with all outputs held.
- All outputs are registered or decoded from registered state only. There are no combinational paths from in_* to out_*.

## Test plan
- Reset mid-REQ (mem_req_ready held 0, rst pulsed) → mem_req_valid=0 next cycle, in_ready=1; a later stray mem_resp_valid produces no out_valid.
- XLEN=32, lb at addr 0x8000_0003, rdata 0x80FF_0000 → out_data 0xFFFF_FF80. lbu at the same address → 0x0000_0080. out_valid 3 cycles after accept with zero-wait bus.
- XLEN=32, sh at 0x8000_0002, wdata 0x1234_ABCD → mem_req_addr 0x8000_0000, wdata 0xABCD_0000, wstrb 0b1100, wen=1.
- lw at 0x8000_0002 → out_fault=1 one cycle after accept, mem_req_valid never asserted. XLEN=32 op 011 → out_fault=1 likewise.
- Load with mem_req_ready delayed 5 cycles, mem_resp_err=1, and out_ready low 3 cycles → request fields stable throughout; out_fault=1 and out_data=0 held until out_ready.
- XLEN=64, lwu at 0x8000_0004, rdata 0xF000_0001_0000_0000 → out_data 0x0000_0000_F000_0001. lw at the same address → 0xFFFF_FFFF_F000_0001.

Source files
------------

// File: rtl/ysyx_24110015_lsu.sv
// Multi-cycle load/store unit: accepts one decoded op, issues at most one bus
// access, and hands the aligned/extended load value (or a fault) to writeback.
module ysyx_24110015_lsu #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    localparam int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [2:0]        in_mem_op,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [STRB_W-1:0] mem_req_wstrb,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [XLEN-1:0]   mem_resp_rdata,
    input  logic              mem_resp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic              out_fault
);
    localparam int OFF_W = $clog2(STRB_W);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] reqAddr_q, reqAddr_d;
    logic [XLEN-1:0]   reqWdata_q, reqWdata_d;
    logic [STRB_W-1:0] reqWstrb_q, reqWstrb_d;
    logic              reqWen_q, reqWen_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              zext_q, zext_d;
    logic [XLEN-1:0]   outData_q, outData_d;
    logic              outFault_q, outFault_d;

    logic [OFF_W-1:0]  inOff;
    logic [1:0]        inSize;
    logic              illegal;
    logic              misaligned;
    logic [15:0]       strbWide;
    logic [XLEN-1:0]   shifted, mask, signPos, loadVal;

    always_comb begin
        inOff    = in_addr[OFF_W-1:0];
        inSize   = in_mem_op[1:0];
        illegal  = (in_mem_op == 3'b111) ||
                   ((XLEN == 32) && ((in_mem_op == 3'b011) || (in_mem_op == 3'b110)));
        case (inSize)
            2'd1:    misaligned = in_addr[0];
            2'd2:    misaligned = |in_addr[1:0];
            2'd3:    misaligned = |in_addr[2:0];
            default: misaligned = 1'b0;
        endcase
        strbWide = ((16'd1 << (5'd1 << inSize)) - 16'd1) << inOff;
    end

    // Size-generic extraction: mask keeps the accessed bytes, ~mask fills the sign.
    always_comb begin
        shifted = mem_resp_rdata >> {off_q, 3'b000};
        mask    = (size_q == 2'd3) ? '1 : ((XLEN'(1) << (7'd8 << size_q)) - XLEN'(1));
        signPos = XLEN'(1) << ((7'd8 << size_q) - 7'd1);
        loadVal = shifted & mask;
        if (!zext_q && (|(shifted & signPos))) begin
            loadVal = loadVal | ~mask;
        end
    end

    always_comb begin
        state_d    = state_q;
        reqAddr_d  = reqAddr_q;
        reqWdata_d = reqWdata_q;
        reqWstrb_d = reqWstrb_q;
        reqWen_d   = reqWen_q;
        off_d      = off_q;
        size_d     = size_q;
        zext_d     = zext_q;
        outData_d  = outData_q;
        outFault_d = outFault_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = DONE;
                    if (in_mem_write || in_mem_read) begin
                        if (illegal || misaligned) begin
                            outData_d  = '0;
                            outFault_d = 1'b1;
                        end else begin
                            reqAddr_d  = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            reqWen_d   = in_mem_write;
                            reqWdata_d = in_wdata << {inOff, 3'b000};
                            reqWstrb_d = in_mem_write ? strbWide[STRB_W-1:0] : '0;
                            off_d      = inOff;
                            size_d     = inSize;
                            zext_d     = in_mem_op[2];
                            state_d    = REQ;
                        end
                    end else begin
                        outData_d  = XLEN'(in_addr);
                        outFault_d = 1'b0;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    outFault_d = mem_resp_err;
                    outData_d  = (mem_resp_err || reqWen_q) ? '0 : loadVal;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            reqAddr_q  <= '0;
            reqWdata_q <= '0;
            reqWstrb_q <= '0;
            reqWen_q   <= 1'b0;
            off_q      <= '0;
            size_q     <= '0;
            zext_q     <= 1'b0;
            outData_q  <= '0;
            outFault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            reqAddr_q  <= reqAddr_d;
            reqWdata_q <= reqWdata_d;
            reqWstrb_q <= reqWstrb_d;
            reqWen_q   <= reqWen_d;
            off_q      <= off_d;
            size_q     <= size_d;
            zext_q     <= zext_d;
            outData_q  <= outData_d;
            outFault_q <= outFault_d;
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign mem_req_valid  = (state_q == REQ);
    assign mem_resp_ready = (state_q == WAIT);
    assign out_valid      = (state_q == DONE);
    assign mem_req_wen    = reqWen_q;
    assign mem_req_addr   = reqAddr_q;
    assign mem_req_wdata  = reqWdata_q;
    assign mem_req_wstrb  = reqWstrb_q;
    assign out_data       = outData_q;
    assign out_fault      = outFault_q;

endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
// Bench for the LSU: one XLEN=32 and one XLEN=64 instance, driven one at a
// time through a shared set of bench signals selected by sel64.
module tb_ysyx_24110015_lsu;

    typedef struct {
        string       name;
        bit          is64;
        bit          rd;
        bit          wr;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        bit          err;
        bit          bus;
        logic [31:0] eAddr;
        logic [63:0] eWdata;
        logic [7:0]  eStrb;
        logic [63:0] eData;
        bit          eFault;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel64 = 1'b0;
    logic        inValid = 1'b0;
    logic        inMemRead = 1'b0;
    logic        inMemWrite = 1'b0;
    logic [2:0]  inMemOp = 3'b000;
    logic [31:0] inAddr = '0;
    logic [63:0] inWdata = '0;
    logic        memReqReady = 1'b0;
    logic        memRespValid = 1'b0;
    logic        memRespErr = 1'b0;
    logic [63:0] respRdata = '0;
    logic        outReady = 1'b0;

    logic        inReady32, reqValid32, reqWen32, respReady32, outValid32, outFault32;
    logic [31:0] reqAddr32, reqWdata32, outData32;
    logic [3:0]  reqWstrb32;
    logic        inReady64, reqValid64, reqWen64, respReady64, outValid64, outFault64;
    logic [31:0] reqAddr64;
    logic [63:0] reqWdata64, outData64;
    logic [7:0]  reqWstrb64;

    logic        inReadyS, reqValidS, reqWenS, respReadyS, outValidS, outFaultS;
    logic [31:0] reqAddrS;
    logic [63:0] reqWdataS, outDataS;
    logic [7:0]  reqWstrbS;

    int checkCount = 0;
    int passCount  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    ysyx_24110015_lsu #(.XLEN(32), .ADDR_W(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(inValid & ~sel64), .in_ready(inReady32),
        .in_addr(inAddr), .in_wdata(inWdata[31:0]),
        .in_mem_read(inMemRead), .in_mem_write(inMemWrite), .in_mem_op(inMemOp),
        .mem_req_valid(reqValid32), .mem_req_ready(memReqReady & ~sel64),
        .mem_req_wen(reqWen32), .mem_req_addr(reqAddr32),
        .mem_req_wdata(reqWdata32), .mem_req_wstrb(reqWstrb32),
        .mem_resp_valid(memRespValid & ~sel64), .mem_resp_ready(respReady32),
        .mem_resp_rdata(respRdata[31:0]), .mem_resp_err(memRespErr),
        .out_valid(outValid32), .out_ready(outReady & ~sel64),
        .out_data(outData32), .out_fault(outFault32)
    );

    ysyx_24110015_lsu #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(inValid & sel64), .in_ready(inReady64),
        .in_addr(inAddr), .in_wdata(inWdata),
        .in_mem_read(inMemRead), .in_mem_write(inMemWrite), .in_mem_op(inMemOp),
        .mem_req_valid(reqValid64), .mem_req_ready(memReqReady & sel64),
        .mem_req_wen(reqWen64), .mem_req_addr(reqAddr64),
        .mem_req_wdata(reqWdata64), .mem_req_wstrb(reqWstrb64),
        .mem_resp_valid(memRespValid & sel64), .mem_resp_ready(respReady64),
        .mem_resp_rdata(respRdata), .mem_resp_err(memRespErr),
        .out_valid(outValid64), .out_ready(outReady & sel64),
        .out_data(outData64), .out_fault(outFault64)
    );

    assign inReadyS   = sel64 ? inReady64   : inReady32;
    assign reqValidS  = sel64 ? reqValid64  : reqValid32;
    assign reqWenS    = sel64 ? reqWen64    : reqWen32;
    assign respReadyS = sel64 ? respReady64 : respReady32;
    assign outValidS  = sel64 ? outValid64  : outValid32;
    assign outFaultS  = sel64 ? outFault64  : outFault32;
    assign reqAddrS   = sel64 ? reqAddr64   : reqAddr32;
    assign reqWdataS  = sel64 ? reqWdata64  : {32'b0, reqWdata32};
    assign reqWstrbS  = sel64 ? reqWstrb64  : {4'b0, reqWstrb32};
    assign outDataS   = sel64 ? outData64   : {32'b0, outData32};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passCount++;
        end
    endtask

    function automatic vec_t mk(string name, bit is64, bit rd, bit wr, logic [2:0] op,
                                logic [31:0] addr, logic [63:0] wdata, logic [63:0] rdata,
                                bit err, bit bus, logic [31:0] eAddr, logic [63:0] eWdata,
                                logic [7:0] eStrb, logic [63:0] eData, bit eFault);
        vec_t v;
        v.name = name; v.is64 = is64; v.rd = rd; v.wr = wr; v.op = op;
        v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err; v.bus = bus;
        v.eAddr = eAddr; v.eWdata = eWdata; v.eStrb = eStrb; v.eData = eData; v.eFault = eFault;
        return v;
    endfunction

    task automatic offer(input bit is64, input bit rd, input bit wr, input logic [2:0] op,
                         input logic [31:0] addr, input logic [63:0] wdata);
        sel64 = is64; inMemRead = rd; inMemWrite = wr; inMemOp = op;
        inAddr = addr; inWdata = wdata; inValid = 1'b1;
        tick();
        inValid = 1'b0; inMemRead = 1'b0; inMemWrite = 1'b0;
    endtask

    // One operation with a zero-wait bus: request at cycle 1, response at cycle 2, result at cycle 3.
    task automatic applyStimulus(input vec_t v);
        offer(v.is64, v.rd, v.wr, v.op, v.addr, v.wdata);
        checkOutput({v.name, ":in_ready_busy"}, inReadyS, 0);
        if (v.bus) begin
            checkOutput({v.name, ":req_valid"}, reqValidS, 1);
            checkOutput({v.name, ":req_wen"}, reqWenS, v.wr);
            checkOutput({v.name, ":req_addr"}, reqAddrS, v.eAddr);
            checkOutput({v.name, ":req_wstrb"}, reqWstrbS, v.eStrb);
            if (v.wr) checkOutput({v.name, ":req_wdata"}, reqWdataS, v.eWdata);
            memReqReady = 1'b1;
            tick();
            memReqReady = 1'b0;
            checkOutput({v.name, ":resp_ready"}, respReadyS, 1);
            checkOutput({v.name, ":early_out"}, outValidS, 0);
            memRespValid = 1'b1; respRdata = v.rdata; memRespErr = v.err;
            tick();
            memRespValid = 1'b0; memRespErr = 1'b0;
        end else begin
            checkOutput({v.name, ":no_bus"}, reqValidS, 0);
        end
        checkOutput({v.name, ":out_valid"}, outValidS, 1);
        checkOutput({v.name, ":out_data"}, outDataS, v.eData);
        checkOutput({v.name, ":out_fault"}, outFaultS, v.eFault);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        checkOutput({v.name, ":back_idle"}, inReadyS, 1);
    endtask

    initial begin
        //           name          64 rd wr op      addr          wdata                  rdata                  err bus eAddr        eWdata                 strb   eData                  flt
        vecs.push_back(mk("lb32",  0, 1, 0, 3'b000, 32'h8000_0003, 64'h0,                 64'h80FF_0000,         0, 1, 32'h8000_0000, 64'h0,                 8'h00, 64'hFFFF_FF80,          0));
        vecs.push_back(mk("lbu32", 0, 1, 0, 3'b100, 32'h8000_0003, 64'h0,                 64'h80FF_0000,         0, 1, 32'h8000_0000, 64'h0,                 8'h00, 64'h0000_0080,          0));
        vecs.push_back(mk("sh32",  0, 0, 1, 3'b001, 32'h8000_0002, 64'h1234_ABCD,         64'hDEAD_BEEF,         0, 1, 32'h8000_0000, 64'hABCD_0000,         8'h0C, 64'h0,                  0));
        vecs.push_back(mk("lwmis", 0, 1, 0, 3'b010, 32'h8000_0002, 64'h0,                 64'h0,                 0, 0, 32'h0,         64'h0,                 8'h00, 64'h0,                  1));
        vecs.push_back(mk("ld32",  0, 1, 0, 3'b011, 32'h8000_0000, 64'h0,                 64'h0,                 0, 0, 32'h0,         64'h0,                 8'h00, 64'h0,                  1));
        vecs.push_back(mk("alu32", 0, 0, 0, 3'b000, 32'h1234_5678, 64'h0,                 64'h0,                 0, 0, 32'h0,         64'h0,                 8'h00, 64'h1234_5678,          0));
        vecs.push_back(mk("lh32",  0, 1, 0, 3'b001, 32'h8000_0002, 64'h0,                 64'h8001_7FFF,         0, 1, 32'h8000_0000, 64'h0,                 8'h00, 64'hFFFF_8001,          0));
        vecs.push_back(mk("lhu32", 0, 1, 0, 3'b101, 32'h8000_0002, 64'h0,                 64'h8001_7FFF,         0, 1, 32'h8000_0000, 64'h0,                 8'h00, 64'h0000_8001,          0));
        vecs.push_back(mk("lw32",  0, 1, 0, 3'b010, 32'h8000_0004, 64'h0,                 64'hCAFE_BABE,         0, 1, 32'h8000_0004, 64'h0,                 8'h00, 64'hCAFE_BABE,          0));
        vecs.push_back(mk("sb32",  0, 0, 1, 3'b000, 32'h8000_0001, 64'h0000_00A5,         64'h0,                 0, 1, 32'h8000_0000, 64'h0000_A500,         8'h02, 64'h0,                  0));
        vecs.push_back(mk("sw32",  0, 0, 1, 3'b010, 32'h8000_000C, 64'h1122_3344,         64'h0,                 0, 1, 32'h8000_000C, 64'h1122_3344,         8'h0F, 64'h0,                  0));
        vecs.push_back(mk("op111", 0, 1, 0, 3'b111, 32'h8000_0000, 64'h0,                 64'h0,                 0, 0, 32'h0,         64'h0,                 8'h00, 64'h0,                  1));
        vecs.push_back(mk("lwerr", 0, 1, 0, 3'b010, 32'h8000_0000, 64'h0,                 64'h5555_AAAA,         1, 1, 32'h8000_0000, 64'h0,                 8'h00, 64'h0,                  1));
        vecs.push_back(mk("rdwr",  0, 1, 1, 3'b000, 32'h8000_0000, 64'h0000_0055,         64'hFFFF_FFFF,         0, 1, 32'h8000_0000, 64'h0000_0055,         8'h01, 64'h0,                  0));
        vecs.push_back(mk("wu32",  0, 1, 0, 3'b110, 32'h8000_0000, 64'h0,                 64'h0,                 0, 0, 32'h0,         64'h0,                 8'h00, 64'h0,                  1));
        vecs.push_back(mk("lwu64", 1, 1, 0, 3'b110, 32'h8000_0004, 64'h0,                 64'hF000_0001_0000_0000, 0, 1, 32'h8000_0000, 64'h0,               8'h00, 64'h0000_0000_F000_0001, 0));
        vecs.push_back(mk("lw64",  1, 1, 0, 3'b010, 32'h8000_0004, 64'h0,                 64'hF000_0001_0000_0000, 0, 1, 32'h8000_0000, 64'h0,               8'h00, 64'hFFFF_FFFF_F000_0001, 0));
        vecs.push_back(mk("sd64",  1, 0, 1, 3'b011, 32'h8000_0008, 64'h0102_0304_0506_0708, 64'h0,               0, 1, 32'h8000_0008, 64'h0102_0304_0506_0708, 8'hFF, 64'h0,                0));
        vecs.push_back(mk("ldmis", 1, 1, 0, 3'b011, 32'h8000_0004, 64'h0,                 64'h0,                 0, 0, 32'h0,         64'h0,                 8'h00, 64'h0,                  1));
        vecs.push_back(mk("sh64",  1, 0, 1, 3'b001, 32'h8000_0006, 64'h0000_BEEF,         64'h0,                 0, 1, 32'h8000_0000, 64'hBEEF_0000_0000_0000, 8'hC0, 64'h0,                0));
        vecs.push_back(mk("lb64",  1, 1, 0, 3'b000, 32'h8000_0007, 64'h0,                 64'h7F00_0000_0000_0000, 0, 1, 32'h8000_0000, 64'h0,               8'h00, 64'h0000_0000_0000_007F, 0));
        vecs.push_back(mk("alu64", 1, 0, 0, 3'b000, 32'hFFFF_FFFF, 64'h0,                 64'h0,                 0, 0, 32'h0,         64'h0,                 8'h00, 64'h0000_0000_FFFF_FFFF, 0));

        rst = 1'b1;
        tick();
        tick();
        checkOutput("rst:in_ready", inReadyS, 1);
        checkOutput("rst:req_valid", reqValidS, 0);
        checkOutput("rst:resp_ready", respReadyS, 0);
        checkOutput("rst:out_valid", outValidS, 0);
        checkOutput("rst:out_data", outDataS, 0);
        checkOutput("rst:out_fault", outFaultS, 0);
        checkOutput("rst:req_addr", reqAddrS, 0);
        checkOutput("rst:req_wstrb", reqWstrbS, 0);
        checkOutput("rst:req_wen", reqWenS, 0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Reset while stuck in REQ, then a stray response must not produce a result.
        offer(0, 1, 0, 3'b000, 32'h8000_0010, 64'h0);
        checkOutput("rstreq:req_valid_pre", reqValidS, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rstreq:req_valid", reqValidS, 0);
        checkOutput("rstreq:in_ready", inReadyS, 1);
        memRespValid = 1'b1; respRdata = 64'h1234_5678;
        tick();
        tick();
        memRespValid = 1'b0;
        checkOutput("rstreq:stray_out", outValidS, 0);
        checkOutput("rstreq:idle", inReadyS, 1);

        // Request stall, late response with bus error, then writeback stall.
        offer(0, 1, 0, 3'b010, 32'h8000_0008, 64'h0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall:req_valid", reqValidS, 1);
            checkOutput("stall:req_addr", reqAddrS, 32'h8000_0008);
            checkOutput("stall:req_wstrb", reqWstrbS, 0);
            checkOutput("stall:req_wen", reqWenS, 0);
            tick();
        end
        memReqReady = 1'b1;
        tick();
        memReqReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checkOutput("stall:resp_ready", respReadyS, 1);
            checkOutput("stall:no_out", outValidS, 0);
            tick();
        end
        memRespValid = 1'b1; memRespErr = 1'b1; respRdata = 64'h1234_5678;
        tick();
        memRespValid = 1'b0; memRespErr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall:out_valid", outValidS, 1);
            checkOutput("stall:out_fault", outFaultS, 1);
            checkOutput("stall:out_data", outDataS, 0);
            checkOutput("stall:in_ready", inReadyS, 0);
            tick();
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        checkOutput("stall:released", outValidS, 0);
        checkOutput("stall:idle", inReadyS, 1);

        // Back-to-back non-memory ops with in_valid held: one op every 2 cycles.
        sel64 = 1'b0; inMemRead = 1'b0; inMemWrite = 1'b0;
        inAddr = 32'h0000_1111; inValid = 1'b1; outReady = 1'b1;
        tick();
        inAddr = 32'h0000_2222;
        checkOutput("b2b:first_valid", outValidS, 1);
        checkOutput("b2b:first_data", outDataS, 32'h0000_1111);
        checkOutput("b2b:no_accept", inReadyS, 0);
        tick();
        checkOutput("b2b:gap_idle", outValidS, 0);
        tick();
        inValid = 1'b0;
        checkOutput("b2b:second_valid", outValidS, 1);
        checkOutput("b2b:second_data", outDataS, 32'h0000_2222);
        tick();
        outReady = 1'b0;
        checkOutput("b2b:idle", inReadyS, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
